alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered decode stage that turns a 32-bit RV32I instruction into the `ALUControl` code, operand selects, immediate and register fields that drive the ALU and register file in the execute stage. It sits between fetch and execute. It uses a valid/ready handshake with one-cycle latency, supports backpressure stalls, and provides a flush input for branch redirect. It also flags unsupported encodings.

## Interface
Parameters:
- none (XLEN fixed at 32)

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `InValid` in 1: `Instr`/`PC` valid this cycle.
- `InReady` out 1: stage can accept; combinational, `!OutValid || OutReady`.
- `Instr` in 32: instruction word.
- `PC` in 32: address of `Instr`.
- `Flush` in 1: discard held and incoming instruction.
- `OutValid` out 1: decoded bundle valid.
- `OutReady` in 1: execute accepts bundle.
- `ALUControl` out 4: ALU operation code.
- `SrcASel` out 1: 0 = rs1, 1 = `PCOut`.
- `SrcBSel` out 1: 0 = rs2, 1 = `ImmExt`.
- `ImmExt` out 32: decoded immediate.
- `Rs1`, `Rs2`, `Rd` out 5 each: register indices.
- `RegWrite` out 1: result is written to `Rd`.
- `IllegalInstr` out 1: encoding not supported.
- `PCOut` out 32: registered `PC`.

## Operation
ALU codes:
- AND 0000, OR 0001, ADD 0010, SUB 0011, SLT 0100, LUI 0110, XOR 0111, SLL 1000, SRL 1001, AUIPC 1010, SLTU 1011, SRA 1100, illegal 1111.

Decode by opcode:
- **0110011 (R):** funct3 selects the op.
  - funct7 = 0100000 is allowed only for funct3 000 (SUB) and 101 (SRA).
  - Any other funct7 ≠ 0000000 is illegal.
  - `SrcBSel` = 0, `RegWrite` = 1.
- **0010011 (I-ALU):** same funct3 map, with ADD for funct3 000.
  - Shifts (001, 101) check imm[11:5]. SLLI needs 0000000. SRLI/SRAI need 0000000 or 0100000. Any other value is illegal.
  - `SrcBSel` = 1, `RegWrite` = 1.
- **0000011 (load), 1100111 (JALR):** ADD, I-imm, `SrcBSel` = 1, `RegWrite` = 1.
- **0100011 (store):** ADD, S-imm, `SrcBSel` = 1, `RegWrite` = 0.
- **1100011 (branch):** B-imm, `SrcBSel` = 0, `RegWrite` = 0.
  - funct3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU; 010/011 → illegal.
- **0110111 (LUI):** LUI code, `ImmExt` = {12'b0, Instr[31:12]} (the ALU applies the <<12), `SrcBSel` = 1, `RegWrite` = 1.
- **0010111 (AUIPC):** AUIPC code, `ImmExt` as LUI, `SrcASel` = 1, `SrcBSel` = 1, `RegWrite` = 1.
- **1101111 (JAL):** ADD, J-imm, `SrcASel` = 1, `SrcBSel` = 1, `RegWrite` = 1.
- **Any other opcode:** illegal.

Field and immediate rules:
- I/S/B/J immediates are sign-extended from Instr[31]. B and J immediates have bit 0 = 0.
- `Rs1`/`Rs2`/`Rd` are always Instr[19:15]/[24:20]/[11:7], whatever the format.
- Illegal instruction: `ALUControl` = 1111, `RegWrite` = 0, `IllegalInstr` = 1, other fields decoded as above. The bundle still propagates with `OutValid`.

## Timing
- Reset (async, `rst_n` low): every output register goes to 0, so `OutValid` = 0 and `ALUControl` = 0000. `InReady` is then 1.
- Load: on a rising edge with `InValid && InReady && !Flush`, capture the decoded bundle and set `OutValid` = 1. Latency is 1 cycle.
- Drain: `OutValid && OutReady` with no new load → `OutValid` = 0 next edge.
- Simultaneous drain and load: back-to-back, full throughput, one instruction per cycle.
- Stall: `OutValid && !OutReady` → `InReady` = 0 and every output holds bit-stable.
- Flush: has priority over everything else. Next edge `OutValid` = 0 and the incoming instruction is dropped. Data fields may hold stale values while `OutValid` = 0.
- Mid-operation reset: the held bundle is lost immediately, with no wait for a clock edge.

## Test plan
- **R-type ALU ops:** `InValid` with 0x002081B3 (add x3,x1,x2), then 0x402081B3 (sub) → next cycle `ALUControl` 0010 then 0011. Both: `Rd` = 3, `Rs1` = 1, `Rs2` = 2, `SrcBSel` = 0, `RegWrite` = 1, `OutValid` held for 1 cycle each.
- **Shift immediate and LUI:**
  - 0x40335293 (srai x5,x6,3) → `ALUControl` 1100, `ImmExt`[4:0] = 3, `SrcBSel` = 1.
  - 0x123450B7 (lui x1,0x12345) → `ALUControl` 0110, `ImmExt` = 0x00012345.
- **Branch and AUIPC:**
  - 0xFE20EEE3 (bltu x1,x2,−4) → `ALUControl` 1011, `ImmExt` = 0xFFFFFFFC, `RegWrite` = 0.
  - AUIPC with `PC` = 0x100 → `SrcASel` = 1, `PCOut` = 0x100.
- **Illegal encodings:** 0x0000007F, 0x022081B3 (funct7 = 0000001) and branch funct3 010 → `IllegalInstr` = 1, `ALUControl` 1111, `RegWrite` = 0.
- **Backpressure and flush:**
  - Hold `OutReady` = 0 for 3 cycles with a valid bundle → `InReady` = 0, outputs unchanged.
  - Release with a new input → back-to-back transfer.
  - Assert `Flush` with `InValid` = 1 → `OutValid` = 0 next cycle.
- **Reset mid-stall:** pull `rst_n` low between clock edges → all outputs 0 immediately. After release, the first accepted instruction appears 1 cycle later.

Source files
------------

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns an instruction into ALU control, operand
// selects, immediate and register fields, registered behind valid/ready.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   InValid/InReady         upstream handshake (Instr, PC)
//   Flush                   drop held and incoming instruction
//   OutValid/OutReady       downstream handshake for the decoded bundle
//   ALUControl, SrcASel, SrcBSel, ImmExt, Rs1, Rs2, Rd, RegWrite,
//   IllegalInstr, PCOut     decoded bundle
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] Instr,
    input  logic [31:0] PC,
    input  logic        Flush,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [3:0]  ALUControl,
    output logic        SrcASel,
    output logic        SrcBSel,
    output logic [31:0] ImmExt,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic [4:0]  Rd,
    output logic        RegWrite,
    output logic        IllegalInstr,
    output logic [31:0] PCOut
);

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0011;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_LUI   = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_AUIPC = 4'b1010;
    localparam logic [3:0] ALU_SLTU  = 4'b1011;
    localparam logic [3:0] ALU_SRA   = 4'b1100;
    localparam logic [3:0] ALU_ILL   = 4'b1111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;
    logic [3:0]  w_alu;
    logic        w_srca;
    logic        w_srcb;
    logic [31:0] w_imm;
    logic        w_rw;
    logic        w_ill;
    logic        w_load;

    logic        r_valid;
    logic [3:0]  r_alu;
    logic        r_srca;
    logic        r_srcb;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic        r_rw;
    logic        r_ill;
    logic [31:0] r_pc;

    assign w_opcode = Instr[6:0];
    assign w_f3     = Instr[14:12];
    assign w_f7     = Instr[31:25];

    assign w_imm_i = {{20{Instr[31]}}, Instr[31:20]};
    assign w_imm_s = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
    assign w_imm_b = {{19{Instr[31]}}, Instr[31], Instr[7],
                      Instr[30:25], Instr[11:8], 1'b0};
    assign w_imm_j = {{11{Instr[31]}}, Instr[31], Instr[19:12],
                      Instr[20], Instr[30:21], 1'b0};
    // The ALU applies the <<12 for LUI/AUIPC, so only the raw field is passed.
    assign w_imm_u = {12'b0, Instr[31:12]};

    function automatic logic [3:0] alu_f3(input logic [2:0] f3);
        logic [3:0] v;
        unique case (f3)
            3'b000:  v = ALU_ADD;
            3'b001:  v = ALU_SLL;
            3'b010:  v = ALU_SLT;
            3'b011:  v = ALU_SLTU;
            3'b100:  v = ALU_XOR;
            3'b101:  v = ALU_SRL;
            3'b110:  v = ALU_OR;
            default: v = ALU_AND;
        endcase
        return v;
    endfunction

    always_comb begin
        w_alu  = ALU_ADD;
        w_srca = 1'b0;
        w_srcb = 1'b0;
        w_imm  = '0;
        w_rw   = 1'b0;
        w_ill  = 1'b0;
        unique case (w_opcode)
            OP_R: begin
                w_alu = alu_f3(w_f3);
                w_rw  = 1'b1;
                if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
                    w_alu = ALU_SUB;
                end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
                    w_alu = ALU_SRA;
                end else if (w_f7 != F7_BASE) begin
                    w_ill = 1'b1;
                end
            end
            OP_I: begin
                w_alu  = alu_f3(w_f3);
                w_srcb = 1'b1;
                w_imm  = w_imm_i;
                w_rw   = 1'b1;
                // Shift amounts live in imm[4:0]; imm[11:5] acts as funct7.
                if (w_f3 == 3'b001 && w_f7 != F7_BASE) begin
                    w_ill = 1'b1;
                end
                if (w_f3 == 3'b101) begin
                    if (w_f7 == F7_ALT) begin
                        w_alu = ALU_SRA;
                    end else if (w_f7 != F7_BASE) begin
                        w_ill = 1'b1;
                    end
                end
            end
            OP_LOAD, OP_JALR: begin
                w_srcb = 1'b1;
                w_imm  = w_imm_i;
                w_rw   = 1'b1;
            end
            OP_STORE: begin
                w_srcb = 1'b1;
                w_imm  = w_imm_s;
            end
            OP_BRANCH: begin
                w_imm = w_imm_b;
                unique case (w_f3[2:1])
                    2'b00:   w_alu = ALU_SUB;
                    2'b10:   w_alu = ALU_SLT;
                    2'b11:   w_alu = ALU_SLTU;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_LUI: begin
                w_alu  = ALU_LUI;
                w_srcb = 1'b1;
                w_imm  = w_imm_u;
                w_rw   = 1'b1;
            end
            OP_AUIPC: begin
                w_alu  = ALU_AUIPC;
                w_srca = 1'b1;
                w_srcb = 1'b1;
                w_imm  = w_imm_u;
                w_rw   = 1'b1;
            end
            OP_JAL: begin
                w_srca = 1'b1;
                w_srcb = 1'b1;
                w_imm  = w_imm_j;
                w_rw   = 1'b1;
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
        if (w_ill) begin
            w_alu = ALU_ILL;
            w_rw  = 1'b0;
        end
    end

    assign InReady = !r_valid || OutReady;
    assign w_load  = InValid && InReady && !Flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_alu   <= '0;
            r_srca  <= 1'b0;
            r_srcb  <= 1'b0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_rw    <= 1'b0;
            r_ill   <= 1'b0;
            r_pc    <= '0;
        end else begin
            if (Flush) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
            end else if (OutReady) begin
                r_valid <= 1'b0;
            end
            // Data only moves on a load, so a stall keeps it bit-stable.
            if (w_load) begin
                r_alu  <= w_alu;
                r_srca <= w_srca;
                r_srcb <= w_srcb;
                r_imm  <= w_imm;
                r_rs1  <= Instr[19:15];
                r_rs2  <= Instr[24:20];
                r_rd   <= Instr[11:7];
                r_rw   <= w_rw;
                r_ill  <= w_ill;
                r_pc   <= PC;
            end
        end
    end

    assign OutValid     = r_valid;
    assign ALUControl   = r_alu;
    assign SrcASel      = r_srca;
    assign SrcBSel      = r_srcb;
    assign ImmExt       = r_imm;
    assign Rs1          = r_rs1;
    assign Rs2          = r_rs2;
    assign Rd           = r_rd;
    assign RegWrite     = r_rw;
    assign IllegalInstr = r_ill;
    assign PCOut        = r_pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed vectors plus a per-cycle
// comparison against a behavioural decode/handshake model.
`timescale 1ns/1ps
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [3:0]  ALUControl;
    logic        SrcASel;
    logic        SrcBSel;
    logic [31:0] ImmExt;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [4:0]  Rd;
    logic        RegWrite;
    logic        IllegalInstr;
    logic [31:0] PCOut;

    alu_decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .InValid(InValid), .InReady(InReady),
        .Instr(Instr), .PC(PC), .Flush(Flush),
        .OutValid(OutValid), .OutReady(OutReady),
        .ALUControl(ALUControl), .SrcASel(SrcASel), .SrcBSel(SrcBSel),
        .ImmExt(ImmExt), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
        .RegWrite(RegWrite), .IllegalInstr(IllegalInstr), .PCOut(PCOut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0]  alu;
        logic        srca;
        logic        srcb;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
        logic        care_imm;
        logic        care_sel;
    } exp_t;

    // funct3 -> ALU code for the plain (non-alternate) ops
    logic [3:0] f3map [8] = '{4'h2, 4'h8, 4'h4, 4'hB,
                              4'h7, 4'h9, 4'h1, 4'h0};

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok;
        logic signed [31:0] s;
        logic [31:0] t;
        e = '0;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        s = $signed(w);
        ok = 1'b1;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd = w[11:7];
        e.care_imm = 1'b1;
        e.care_sel = 1'b1;
        e.alu = 4'h2;
        case (op)
            7'h33: begin
                e.alu = f3map[f3];
                e.rw = 1'b1;
                e.care_imm = 1'b0;
                if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'h3;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'hC;
                else if (f7 != 7'h00) ok = 1'b0;
            end
            7'h13: begin
                e.alu = f3map[f3];
                e.srcb = 1'b1;
                e.rw = 1'b1;
                t = s >>> 20;
                e.imm = t;
                if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) e.alu = 4'hC;
                    else if (f7 != 7'h00) ok = 1'b0;
                end
            end
            7'h03, 7'h67: begin
                e.srcb = 1'b1;
                e.rw = 1'b1;
                t = s >>> 20;
                e.imm = t;
            end
            7'h23: begin
                e.srcb = 1'b1;
                t = s >>> 20;
                e.imm = (t & 32'hFFFF_FFE0) | {27'b0, w[11:7]};
            end
            7'h63: begin
                t = s >>> 19;
                e.imm = (t & 32'hFFFF_F000) | ({31'b0, w[7]} << 11)
                      | ({26'b0, w[30:25]} << 5) | ({28'b0, w[11:8]} << 1);
                if (f3 <= 3'd1) e.alu = 4'h3;
                else if (f3 <= 3'd3) ok = 1'b0;
                else if (f3 <= 3'd5) e.alu = 4'h4;
                else e.alu = 4'hB;
            end
            7'h37: begin
                e.alu = 4'h6;
                e.srcb = 1'b1;
                e.rw = 1'b1;
                e.imm = w >> 12;
            end
            7'h17: begin
                e.alu = 4'hA;
                e.srca = 1'b1;
                e.srcb = 1'b1;
                e.rw = 1'b1;
                e.imm = w >> 12;
            end
            7'h6F: begin
                e.srca = 1'b1;
                e.srcb = 1'b1;
                e.rw = 1'b1;
                t = s >>> 11;
                e.imm = (t & 32'hFFF0_0000) | (w & 32'h000F_F000)
                      | ({31'b0, w[20]} << 11) | ({22'b0, w[30:21]} << 1);
            end
            default: begin
                ok = 1'b0;
                e.care_imm = 1'b0;
                e.care_sel = 1'b0;
            end
        endcase
        if (!ok) begin
            e.alu = 4'hF;
            e.rw = 1'b0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e = '0;
        e.care_imm = 1'b1;
        e.care_sel = 1'b1;
        return e;
    endfunction

    logic        mv = 1'b0;
    logic        mzero = 1'b1;
    exp_t        me = '0;
    logic [31:0] mpc = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv <= 1'b0;
            mzero <= 1'b1;
            me <= zero_exp();
            mpc <= '0;
        end else begin
            if (Flush) begin
                mv <= 1'b0;
            end else if (InValid && (!mv || OutReady)) begin
                mv <= 1'b1;
                mzero <= 1'b0;
                me <= model(Instr);
                mpc <= PC;
            end else if (OutReady) begin
                mv <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_OutValid", 32'(OutValid), 32'(mv));
            check("m_InReady", 32'(InReady), 32'(!mv || OutReady));
            if (mv || mzero) begin
                check("m_ALUControl", 32'(ALUControl), 32'(me.alu));
                check("m_Rs1", 32'(Rs1), 32'(me.rs1));
                check("m_Rs2", 32'(Rs2), 32'(me.rs2));
                check("m_Rd", 32'(Rd), 32'(me.rd));
                check("m_RegWrite", 32'(RegWrite), 32'(me.rw));
                check("m_Illegal", 32'(IllegalInstr), 32'(me.ill));
                check("m_PCOut", PCOut, mpc);
                if (me.care_sel) begin
                    check("m_SrcASel", 32'(SrcASel), 32'(me.srca));
                    check("m_SrcBSel", 32'(SrcBSel), 32'(me.srcb));
                end
                if (me.care_imm) check("m_ImmExt", ImmExt, me.imm);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                            7'h63, 7'h37, 7'h17, 7'h6F};

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            w[6:0] = ops[$urandom_range(0, 8)];
            if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) &&
                $urandom_range(0, 3) != 0)
                w[31:25] = $urandom_range(0, 1) != 0 ? 7'h20 : 7'h00;
        end
        return w;
    endfunction

    logic [31:0] ill_vec [3] = '{32'h0000_007F, 32'h0220_81B3,
                                 32'h0020_A063};

    initial begin
        InValid = 1'b0;
        Instr = '0;
        PC = '0;
        Flush = 1'b0;
        OutReady = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_OutValid", 32'(OutValid), 32'h0);
        check("rst_ALUControl", 32'(ALUControl), 32'h0);
        check("rst_InReady", 32'(InReady), 32'h1);
        #9 rst_n = 1'b1;

        InValid = 1'b1; Instr = 32'h0020_81B3; PC = 32'h10;
        cyc();
        check("add_alu", 32'(ALUControl), 32'h2);
        check("add_rd", 32'(Rd), 32'd3);
        check("add_rs1", 32'(Rs1), 32'd1);
        check("add_rs2", 32'(Rs2), 32'd2);
        check("add_srcb", 32'(SrcBSel), 32'h0);
        check("add_rw", 32'(RegWrite), 32'h1);
        check("add_valid", 32'(OutValid), 32'h1);
        Instr = 32'h4020_81B3; PC = 32'h14;
        cyc();
        check("sub_alu", 32'(ALUControl), 32'h3);
        check("sub_rd", 32'(Rd), 32'd3);
        check("sub_valid", 32'(OutValid), 32'h1);
        InValid = 1'b0;
        cyc();
        check("drain_valid", 32'(OutValid), 32'h0);

        InValid = 1'b1; Instr = 32'h4033_5293;
        cyc();
        check("srai_alu", 32'(ALUControl), 32'hC);
        check("srai_sh", 32'(ImmExt[4:0]), 32'd3);
        check("srai_srcb", 32'(SrcBSel), 32'h1);
        Instr = 32'h1234_50B7;
        cyc();
        check("lui_alu", 32'(ALUControl), 32'h6);
        check("lui_imm", ImmExt, 32'h0001_2345);
        Instr = 32'hFE20_EEE3;
        cyc();
        check("bltu_alu", 32'(ALUControl), 32'hB);
        check("bltu_imm", ImmExt, 32'hFFFF_FFFC);
        check("bltu_rw", 32'(RegWrite), 32'h0);
        Instr = 32'h0000_0117; PC = 32'h100;
        cyc();
        check("auipc_alu", 32'(ALUControl), 32'hA);
        check("auipc_srca", 32'(SrcASel), 32'h1);
        check("auipc_pc", PCOut, 32'h100);

        for (int i = 0; i < 3; i++) begin
            Instr = ill_vec[i];
            cyc();
            check("ill_flag", 32'(IllegalInstr), 32'h1);
            check("ill_alu", 32'(ALUControl), 32'hF);
            check("ill_rw", 32'(RegWrite), 32'h0);
            check("ill_valid", 32'(OutValid), 32'h1);
        end

        Instr = 32'h0050_0093; PC = 32'h200;
        cyc();
        check("bp_imm", ImmExt, 32'd5);
        OutReady = 1'b0; Instr = 32'h0FF0_C093; PC = 32'h204;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_inready", 32'(InReady), 32'h0);
            check("stall_valid", 32'(OutValid), 32'h1);
            check("stall_imm", ImmExt, 32'd5);
            check("stall_pc", PCOut, 32'h200);
            check("stall_alu", 32'(ALUControl), 32'h2);
        end
        OutReady = 1'b1;
        cyc();
        check("rel_pc", PCOut, 32'h204);
        check("rel_alu", 32'(ALUControl), 32'h7);
        check("rel_imm", ImmExt, 32'h0000_00FF);
        Instr = 32'h00A0_0113; PC = 32'h208;
        cyc();
        check("b2b_pc", PCOut, 32'h208);
        check("b2b_valid", 32'(OutValid), 32'h1);
        check("b2b_imm", ImmExt, 32'd10);

        Instr = 32'h00B0_0193; PC = 32'h20C; Flush = 1'b1;
        cyc();
        check("flush_valid", 32'(OutValid), 32'h0);
        Flush = 1'b0; InValid = 1'b0;
        cyc();
        check("flush_gone", 32'(OutValid), 32'h0);

        InValid = 1'b1; Instr = 32'h00C0_0213; PC = 32'h300;
        cyc();
        OutReady = 1'b0; InValid = 1'b0;
        cyc();
        check("pre_rst_valid", 32'(OutValid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_fields", {OutValid, ALUControl, SrcASel, SrcBSel,
                              Rs1, Rs2, Rd, RegWrite, IllegalInstr}, 32'h0);
        check("arst_imm", ImmExt, 32'h0);
        check("arst_pc", PCOut, 32'h0);
        check("arst_inready", 32'(InReady), 32'h1);
        #1 rst_n = 1'b1;
        OutReady = 1'b1; InValid = 1'b1;
        Instr = 32'h00D0_0293; PC = 32'h400;
        cyc();
        check("post_rst_valid", 32'(OutValid), 32'h1);
        check("post_rst_imm", ImmExt, 32'd13);
        check("post_rst_pc", PCOut, 32'h400);
        check("post_rst_rd", 32'(Rd), 32'd5);
        InValid = 1'b0;
        cyc();

        for (int i = 0; i < 400; i++) begin
            InValid = $urandom_range(0, 3) != 0;
            OutReady = $urandom_range(0, 3) != 0;
            Flush = $urandom_range(0, 15) == 0;
            Instr = rand_instr();
            PC = $urandom & 32'hFFFF_FFFC;
            cyc();
        end
        InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
